// File: rtl/common_pkg.sv
// common_pkg: shared types and default sizing for the tree NoC.
// Holds the leaf injector buffer entry and its default constants.
package common_pkg;

    localparam int DEFAULT_N             = 32;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 32;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;

    localparam int INJ_SRC_FIFO_DEPTH_DEFAULT = 4;

    localparam int DEFAULT_A_W = $clog2(DEFAULT_N) + 1;

    // VC index width; a single VC still gets a 1-bit index field.
    function automatic int vc_idx_w(input int vcs);
        return (vcs > 1) ? $clog2(vcs) : 1;
    endfunction

    localparam int DEFAULT_VCI_W = vc_idx_w(DEFAULT_VC_W);

    // Injector buffer entry at default sizing.
    typedef struct packed {
        logic [DEFAULT_VCI_W-1:0] vc;
        logic [DEFAULT_A_W-1:0]   dest;
        logic [DEFAULT_D_W-1:0]   data;
    } inj_entry_t;

endpackage

// File: rtl/noc_if.sv
// noc_if: one credit-based tree link.
// vc_target is one-hot (zero = idle); credits flow back per VC.
interface noc_if #(
    parameter int VC_W = 2,
    parameter int A_W  = 6,
    parameter int D_W  = 32
);

    logic [VC_W-1:0]    vc_target;
    logic [A_W+D_W-1:0] packet;
    logic [VC_W-1:0]    vc_credit_gnt;

    modport transmitter (
        output vc_target,
        output packet,
        input  vc_credit_gnt
    );

    modport receiver (
        input  vc_target,
        input  packet,
        output vc_credit_gnt
    );

endinterface

// File: rtl/noc_inj_fifo.sv
// noc_inj_fifo: synchronous FIFO with registered full/empty/count.
// Push while full is dropped even if a pop happens in the same cycle.
module noc_inj_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage array; contents only matter while occupied
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/noc_leaf_injector.sv
// noc_leaf_injector: leaf transmitter with per-VC credit tracking.
// Optional NOC_INJ_STATS_EN adds sent-flit and credit-stall counters.
module noc_leaf_injector
    import common_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int VC_W           = DEFAULT_VC_W,
    parameter int D_W            = DEFAULT_D_W,
    parameter int VC_FIFO_DEPTH  = DEFAULT_VC_FIFO_DEPTH,
    parameter int SRC_FIFO_DEPTH = INJ_SRC_FIFO_DEPTH_DEFAULT,
    localparam int A_W           = $clog2(N) + 1,
    localparam int VCI_W         = vc_idx_w(VC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [VCI_W-1:0] src_vc,
    input  logic [A_W-1:0]   src_dest,
    input  logic [D_W-1:0]   src_data,
    noc_if.transmitter       tx,
    output logic [VC_W-1:0]  credits_avail
`ifdef NOC_INJ_STATS_EN
    ,
    output logic [31:0]      stat_flits_sent,
    output logic [31:0]      stat_credit_stall
`endif
);

    localparam int CRW = $clog2(VC_FIFO_DEPTH);
    localparam int FCW = $clog2(SRC_FIFO_DEPTH) + 1;
    localparam logic [CRW-1:0] CRED_MAX = CRW'(VC_FIFO_DEPTH - 1);

    typedef struct packed {
        logic [VCI_W-1:0] vc;
        logic [A_W-1:0]   dest;
        logic [D_W-1:0]   data;
    } entry_t;

    entry_t             push_e;
    entry_t             head_e;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCW-1:0]     fifo_cnt;
    logic               rdy_q;
    logic [VC_W-1:0]    head_oh;
    logic [VC_W-1:0]    send_oh;
    logic               send;
    logic [CRW-1:0]     cred_q [VC_W];
    logic [CRW-1:0]     cred_d [VC_W];
    logic [VC_W-1:0]    vc_target_q;
    logic [A_W+D_W-1:0] packet_q;

    assign push_e    = {src_vc, src_dest, src_data};
    assign src_ready = rdy_q && !fifo_full;

    noc_inj_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (SRC_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (src_valid && src_ready),
        .pop_i   (send),
        .data_i  (push_e),
        .data_o  (head_e),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Ready is held low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Decode head VC to one-hot; out-of-range indices match nothing
    always_comb begin
        head_oh = '0;
        for (int v = 0; v < VC_W; v++) begin
            head_oh[v] = (head_e.vc == VCI_W'(v));
        end
    end

    assign send    = !fifo_empty && |(head_oh & credits_avail);
    assign send_oh = send ? head_oh : '0;

    // Credit bookkeeping: send consumes, grant returns, both cancel
    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            cred_d[v] = cred_q[v];
            unique case ({send_oh[v], tx.vc_credit_gnt[v]})
                2'b10: cred_d[v] = cred_q[v] - CRW'(1);
                2'b01: cred_d[v] = (cred_q[v] == CRED_MAX)
                                 ? CRED_MAX
                                 : cred_q[v] + CRW'(1);
                default: ;
            endcase
        end
    end

    // Credit counters start full so the downstream FIFO is assumed empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_W; v++) begin
                cred_q[v] <= CRED_MAX;
            end
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                cred_q[v] <= cred_d[v];
            end
        end
    end

    // Nonzero-credit flags straight from the counters
    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            credits_avail[v] = (cred_q[v] != '0);
        end
    end

    // Registered link outputs; packet holds across idle cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vc_target_q <= '0;
            packet_q    <= '0;
        end else begin
            vc_target_q <= send_oh;
            if (send) begin
                packet_q <= {head_e.dest, head_e.data};
            end
        end
    end

    assign tx.vc_target = vc_target_q;
    assign tx.packet    = packet_q;

`ifdef NOC_INJ_STATS_EN
    logic [31:0] sent_q;
    logic [31:0] stall_q;

    // Wrapping counters for sends and head-of-line credit stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            sent_q  <= sent_q + 32'(send);
            stall_q <= stall_q + 32'(!fifo_empty && !send);
        end
    end

    assign stat_flits_sent   = sent_q;
    assign stat_credit_stall = stall_q;
`endif

`ifndef SYNTHESIS
    a_full_cnt: assert property (@(posedge clk) disable iff (!rst)
        fifo_full == (fifo_cnt == FCW'(SRC_FIFO_DEPTH)));

    for (genvar v = 0; v < VC_W; v++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
            !(tx.vc_credit_gnt[v] && !send_oh[v] && cred_q[v] == CRED_MAX));
    end
`endif

endmodule

// File: doc/noc_leaf_injector.md
# noc_leaf_injector

- Leaf-side transmitter endpoint for the credit-based binary-tree NoC. Drives one tree leaf receive port.
- Accepts flits from a local client over a valid/ready handshake and buffers them in a small FIFO.
- Tracks per-VC downstream credits and emits a flit onto the `noc_if` transmitter only when its VC has a credit.
- Sits between a PE/traffic generator and a topology leaf port, one instance per leaf.

## Interface
- `N`, 32: number of leaves, power of 2; `A_W = $clog2(N)+1`.
- `VC_W`, `DEFAULT_VC_W`: number of virtual channels.
- `D_W`, `DEFAULT_D_W`: payload width.
- `VC_FIFO_DEPTH`, `DEFAULT_VC_FIFO_DEPTH`: downstream per-VC FIFO parameter; initial credits per VC = `VC_FIFO_DEPTH-1`.
- `SRC_FIFO_DEPTH`, 4: local input FIFO entries, power of 2, ≥2.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `src_valid`  input  1  client flit valid.
- `src_ready`  output  1  FIFO can accept.
- `src_vc`  input  `$clog2(VC_W)` (min 1)  VC index of the flit.
- `src_dest`  input  `A_W`  destination address.
- `src_data`  input  `D_W`  payload.
- `tx`  modport  `noc_if.transmitter`  (`vc_target` out `VC_W` one-hot, zero = idle; `packet` out `A_W+D_W` = {dest, data}; `vc_credit_gnt` in `VC_W`, one credit returned per set bit per cycle).
- `credits_avail`  output  `VC_W`  bit v = VC v credit counter nonzero.

## Operation
- Client handshake: a flit is captured when `src_valid && src_ready`. `src_ready = !fifo_full`.
- FIFO entry = {vc, dest, data}. Strict order; a single FIFO means head-of-line blocking is intended.
- Credit counters: one per VC, width `$clog2(VC_FIFO_DEPTH)`.
- Send condition: FIFO non-empty and `credit[head.vc] != 0`. On send, pop the head, register `vc_target = 1<<head.vc` and `packet = {dest, data}`, and decrement that credit.
- Idle cycle: `vc_target = 0`; `packet` holds its last value.
- Credit return: each set bit of `vc_credit_gnt` increments its counter.
- Same-VC send and grant in one cycle: counter unchanged.
- Grant that would exceed `VC_FIFO_DEPTH-1`: counter saturates. Simulation assertion fires.
- FIFO full and pop in the same cycle: `src_ready` stays 0 that cycle, since it is derived from registered occupancy; the push is refused.
- FIFO empty with a push: no bypass. The flit is sent no earlier than the next cycle.

## Timing
- Reset (`rst` low, async): `vc_target = 0`, `packet = 0`, FIFO empty, `src_ready = 0` while asserted, credits = `VC_FIFO_DEPTH-1`, `credits_avail` = all ones.
- After deassertion:
  - `src_ready = 1` on the first clock edge.
  - Reset mid-operation discards buffered flits and restores full credits.
  - The downstream side must be reset concurrently.
- Latency: capture at edge k, earliest `tx` valid at edge k+1 (output registered).
- Throughput: one flit per cycle while the head VC has credit.
- Credit visibility: a grant sampled at edge k can enable a send at edge k+1.
- `credits_avail` is combinational from the counters.

## Configuration
- `NOC_INJ_STATS_EN` defined: adds 32-bit wrapping counters, cleared by reset, readable as outputs:
  - `stat_flits_sent`
  - `stat_credit_stall` (cycles with FIFO non-empty but head VC at zero credit).
- Undefined: counters and ports are absent and behaviour is otherwise identical.

## Structure
- `common_pkg` gains:
  - the `inj_entry_t` struct {vc, dest, data};
  - the `INJ_SRC_FIFO_DEPTH_DEFAULT` constant.
- Sub-module `noc_inj_fifo`: a synchronous FIFO with registered full/empty and count, parameterized by width and depth, async active-low reset.
- Credit counters and the send logic live in the top module.

## Test plan
- Reset, then 3 flits on VC0 (dest 5, data 0xA1/0xA2/0xA3), no grants, `VC_FIFO_DEPTH=4` → exactly 3 sends on consecutive cycles, `vc_target = 0b01`, and `credits_avail[0]` falls to 0.
- Continuing from the previous case, a 4th flit is pushed → it stays buffered. A grant pulse on VC0 at edge k → the flit appears at edge k+1.
- Head on VC0 with zero credits, next flit on VC1 with credits → nothing sent (HOL blocking), and `stat_credit_stall` increments each cycle when enabled.
- Fill the FIFO with `SRC_FIFO_DEPTH` flits while starved of credit → `src_ready = 0`, the extra `src_valid` is not captured, and order is preserved after credits return.
- Send and grant on VC1 in the same cycle with credit 1 → counter stays 1 and the next flit is sent the following cycle.
- Assert `rst` while 2 flits are buffered and credits are partially used → `vc_target = 0` immediately, and after release all credits = `VC_FIFO_DEPTH-1` and no stale flit is emitted.
